joy_serial_reader: RTL and testbench

Master side of the DB9/JAMMA serial joystick link. It generates `joy_clk` and `joy_load_n` for an external 74HC165-style parallel-in/serial-out chain, shifts in one frame of button bits from `joy_data`, and presents the frame as an active-high button vector. It sits in the top level next to the joystick pins and feeds the core's joystick inputs. It replaces the pass-through of an externally generated clock and load.

---
 rtl/joy_serial_reader.sv | 160 ++++++++++++++++
 tb/tb_joy_serial_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_reader.sv
// Master for a 74HC165-style serial joystick chain: generates load/shift strobes,
// shifts in NBITS active-low buttons. Optional two-frame debounce: JOYREAD_DEBOUNCE_EN.
module joy_serial_reader #(
  parameter int CLK_DIV    = 25,
  parameter int NBITS      = 16,
  parameter int GAP_CYCLES = 1000
) (
  input  logic             clk50mhz,
  input  logic             rst_n,
  output logic             joy_clk,
  output logic             joy_load_n,
  input  logic             joy_data,
  output logic [NBITS-1:0] joy_state,
  output logic             frame_valid
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NBITS);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             load_phase, load_phase_nxt;
  logic [IDX_W-1:0] bit_idx, idx_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [NBITS-1:0] raw, raw_nxt;
  logic             sync1, sync2;
  logic             phase_end;
  logic             accept;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // LOAD spans two divider phases, tracked by load_phase.
  always_comb begin
    state_nxt      = state;
    div_nxt        = '0;
    load_phase_nxt = load_phase;
    idx_nxt        = bit_idx;
    gap_nxt        = '0;
    raw_nxt        = raw;
    unique case (state)
      LOAD: begin
        div_nxt = phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) begin
          load_phase_nxt = ~load_phase;
          if (load_phase) begin
            state_nxt = SHIFT_LO;
            idx_nxt   = '0;
          end
        end
      end
      SHIFT_LO: begin
        div_nxt = phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) begin
          raw_nxt   = {raw[NBITS-2:0], sync2};
          state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        div_nxt = phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) begin
          if (bit_idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = bit_idx + 1'b1;
            state_nxt = SHIFT_LO;
          end
        end
      end
      DONE: begin
        state_nxt = (GAP_CYCLES == 0) ? LOAD : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = LOAD;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      load_phase <= 1'b0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      raw        <= '1;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
    end else begin
      div_cnt    <= div_nxt;
      load_phase <= load_phase_nxt;
      bit_idx    <= idx_nxt;
      gap_cnt    <= gap_nxt;
      raw        <= raw_nxt;
      sync1      <= joy_data;
      sync2      <= sync1;
    end
  end

`ifdef JOYREAD_DEBOUNCE_EN
  logic [NBITS-1:0] prev_raw;

  assign accept = (raw == prev_raw);

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw <= '1;
    end else if (state == DONE) begin
      prev_raw <= raw;
    end
  end
`else
  assign accept = 1'b1;
`endif

  // Outputs are a registered decode of the current state, so every strobe
  // lags the state register by exactly one cycle.
  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      joy_clk     <= 1'b0;
      joy_load_n  <= 1'b1;
      frame_valid <= 1'b0;
      joy_state   <= '0;
    end else begin
      joy_clk     <= (state == SHIFT_HI);
      joy_load_n  <= (state != LOAD);
      frame_valid <= (state == DONE);
      if ((state == DONE) && accept) begin
        joy_state <= ~raw;
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_reader.sv
// Scoreboard bench for joy_serial_reader: a 74HC165 chain model issues frames,
// a word-level button model predicts joy_state, a monitor checks on frame_valid.
`timescale 1ns/1ps
module tb_joy_serial_reader;

  localparam int CLK_DIV      = 25;
  localparam int NBITS        = 16;
  localparam int GAP_CYCLES   = 1000;
  localparam int FIRST_VALID  = 2 * CLK_DIV * (NBITS + 1) + 1;
  localparam int FRAME_CYCLES = FIRST_VALID + GAP_CYCLES;
  localparam int N_RANDOM     = 8;

  logic             clk50mhz = 1'b0;
  logic             rst_n = 1'b0;
  logic             joy_clk;
  logic             joy_load_n;
  logic             joy_data;
  logic [NBITS-1:0] joy_state;
  logic             frame_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rel_cyc = 0;

  logic [NBITS-1:0] frame_q[$];
  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] chain_sr = '1;
  logic             noise = 1'b0;
  logic [NBITS-1:0] model_state = '0;
`ifdef JOYREAD_DEBOUNCE_EN
  logic [NBITS-1:0] model_prev = '1;
`endif

  joy_serial_reader #(
    .CLK_DIV   (CLK_DIV),
    .NBITS     (NBITS),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk50mhz   (clk50mhz),
    .rst_n      (rst_n),
    .joy_clk    (joy_clk),
    .joy_load_n (joy_load_n),
    .joy_data   (joy_data),
    .joy_state  (joy_state),
    .frame_valid(frame_valid)
  );

  always #10 clk50mhz = ~clk50mhz;

  always @(posedge clk50mhz) cyc <= cyc + 1;

  // Chain output, corrupted by asynchronous noise only while no sample is near.
  assign joy_data = chain_sr[NBITS-1] ^ (noise & (joy_clk | ~joy_load_n));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NBITS-1:0] word);
    frame_q.push_back(word);
  endtask

  function automatic logic [NBITS-1:0] modelFrame(input logic [NBITS-1:0] word);
`ifdef JOYREAD_DEBOUNCE_EN
    if (word == model_prev) model_state = ~word;
    model_prev = word;
`else
    model_state = ~word;
`endif
    return model_state;
  endfunction

  task automatic resetModel();
    model_state = '0;
`ifdef JOYREAD_DEBOUNCE_EN
    model_prev = '1;
`endif
  endtask

  task automatic waitDrained(input string name);
    int budget = (frame_q.size() + 2) * FRAME_CYCLES + 100;
    int i = 0;
    while ((frame_q.size() != 0 || exp_q.size() != 0) && i < budget) begin
      @(negedge clk50mhz);
      i++;
    end
    checkOutput(name, frame_q.size() + exp_q.size(), 0);
  endtask

  // Chain model: parallel load on load_n, shift toward Q7 on joy_clk rise, serial-in tied high.
  initial begin
    logic [NBITS-1:0] word;
    forever begin
      @(negedge joy_load_n);
      word = (frame_q.size() != 0) ? frame_q.pop_front() : '1;
      chain_sr = word;
      exp_q.push_back(modelFrame(word));
    end
  end

  initial begin
    forever begin
      @(posedge joy_clk);
      if (joy_load_n) chain_sr = {chain_sr[NBITS-2:0], 1'b1};
    end
  end

  initial begin
    forever begin
      #($urandom_range(1, 23));
      noise = ~noise;
    end
  end

  // Monitor: strobe shape, frame timing and scoreboard comparison.
  initial begin
    int   load_run = 0;
    int   rises = 0;
    int   last_valid = -1;
    logic prev_clk = 1'b0;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk50mhz);
      if (!rst_n) begin
        load_run   = 0;
        rises      = 0;
        last_valid = -1;
        prev_clk   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (!joy_load_n) begin
          load_run++;
          rises = 0;
        end else if (load_run != 0) begin
          checkOutput("load_width", load_run, 2 * CLK_DIV);
          load_run = 0;
        end
        if (joy_clk && !prev_clk) rises++;
        prev_clk = joy_clk;
        if (frame_valid) begin
          checkOutput("valid_back_to_back", prev_valid, 0);
          checkOutput("clk_rises", rises, NBITS);
          if (last_valid < 0) checkOutput("first_valid_cycle", cyc - rel_cyc, FIRST_VALID);
          else checkOutput("valid_period", cyc - last_valid, FRAME_CYCLES);
          last_valid = cyc;
          if (exp_q.size() == 0) checkOutput("unexpected_frame", 1, 0);
          else checkOutput("joy_state", joy_state, exp_q.pop_front());
        end
        prev_valid = frame_valid;
      end
    end
  end

  initial begin
    logic [NBITS-1:0] word;
    int               rises_seen;
    logic             last_clk;
    logic             found;

    rst_n = 1'b0;
    repeat (3) @(negedge clk50mhz);
    checkOutput("reset_joy_clk", joy_clk, 0);
    checkOutput("reset_load_n", joy_load_n, 1);
    checkOutput("reset_joy_state", joy_state, 0);
    checkOutput("reset_frame_valid", frame_valid, 0);

    applyStimulus(16'hFFFF);
    applyStimulus(16'hFF7E);
    applyStimulus(16'hFF7E);
    applyStimulus(16'hFFFE);
    applyStimulus(16'hFFFF);
    applyStimulus(16'hFFFE);
    applyStimulus(16'hFFFE);
    applyStimulus(16'h7FFF);
    applyStimulus(16'h7FFF);
    applyStimulus(16'h0000);
    for (int i = 0; i < N_RANDOM; i++) begin
      word = NBITS'($urandom);
      applyStimulus(word);
      if ($urandom_range(0, 1) == 1) applyStimulus(word);
    end
    applyStimulus(16'h1234);
    applyStimulus(16'h1234);

    @(negedge clk50mhz);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    waitDrained("drain_main");

    // Abort a frame during SHIFT_HI of bit 7.
    applyStimulus(16'hABCD);
    found = 1'b0;
    for (int i = 0; i < FRAME_CYCLES && !found; i++) begin
      @(negedge clk50mhz);
      if (!joy_load_n) found = 1'b1;
    end
    rises_seen = 0;
    last_clk   = 1'b0;
    for (int i = 0; i < 2 * CLK_DIV * NBITS && found && rises_seen < 8; i++) begin
      @(negedge clk50mhz);
      if (joy_clk && !last_clk) rises_seen++;
      last_clk = joy_clk;
    end
    checkOutput("reach_bit7_shift_hi", rises_seen, 8);
    #63;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_joy_clk", joy_clk, 0);
    checkOutput("midreset_load_n", joy_load_n, 1);
    checkOutput("midreset_joy_state", joy_state, 0);
    checkOutput("midreset_frame_valid", frame_valid, 0);
    exp_q.delete();
    frame_q.delete();
    resetModel();

    applyStimulus(16'h5AA5);
    applyStimulus(16'h5AA5);
    applyStimulus(NBITS'($urandom));
    repeat (3) @(negedge clk50mhz);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    waitDrained("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
